// File: rtl/tri_fetch_sched.sv
// Per-frame triangle fetch sequencer: latches pose, reads triangles from BRAM, streams them out.
// Latency: first read 1 cycle after start, first triangle 2+RAM_LAT; backpressure: credit-gated reads into output FIFO.

module tri_fetch_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               head_dat,
    output logic                       head_vld,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          do_pop, do_push, full;

    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && (count != '0);
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];
    assign head_vld = (count != '0);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // The upstream credit scheme must never present a push the FIFO cannot take.
    always_ff @(posedge clk_in) begin
        if (!rst_in) assert (!(push && full && !do_pop));
    end
endmodule

module tri_fetch_sched #(
    parameter int ADDR_W     = 16,
    parameter int TRI_W      = 96,
    parameter int RAM_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              frame_start_in,
    input  logic [ADDR_W-1:0] num_tris_in,
    input  logic [223:0]      pose_in,
    output logic [223:0]      pose_out,
    output logic              busy_out,
    output logic              frame_done_out,
    output logic [ADDR_W-1:0] ram_addr_out,
    output logic              ram_en_out,
    input  logic [TRI_W-1:0]  ram_data_in,
    output logic [TRI_W-1:0]  tri_out,
    output logic [ADDR_W-1:0] tri_idx_out,
    output logic              tri_valid_out,
    input  logic              tri_ready_in
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_W:0]         issued, accepted, num_ext;
    logic [ADDR_W-1:0]       num_tris;
    logic [RAM_LAT-1:0]      vld_pipe;
    logic [ADDR_W-1:0]       idx_pipe [RAM_LAT];
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                    issue, pop, credit_ok, done_nxt, start_ok;

    assign num_ext   = {1'b0, num_tris};
    assign start_ok  = (state == IDLE) && frame_start_in;
    assign pop       = tri_valid_out && tri_ready_in;
    // Reserve a FIFO slot for every read already in the BRAM pipe.
    assign credit_ok = ($countones(vld_pipe) + 32'(fifo_count)) < FIFO_DEPTH;

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start_in) begin
                    if (num_tris_in == '0) done_nxt = 1'b1;
                    else                   state_nxt = FETCH;
                end
            end
            FETCH: begin
                issue = (issued < num_ext) && credit_ok;
                if (issue && (issued + 1'b1 == num_ext)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (accepted + (ADDR_W+1)'(pop) == num_ext) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ram_en_out   = issue;
    assign ram_addr_out = issued[ADDR_W-1:0];
    assign busy_out     = (state != IDLE);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= IDLE;
            issued         <= '0;
            accepted       <= '0;
            num_tris       <= '0;
            pose_out       <= '0;
            frame_done_out <= 1'b0;
            vld_pipe       <= '0;
            for (int i = 0; i < RAM_LAT; i++) idx_pipe[i] <= '0;
        end else begin
            state          <= state_nxt;
            frame_done_out <= done_nxt;
            if (start_ok) begin
                pose_out <= pose_in;
                num_tris <= num_tris_in;
                issued   <= '0;
                accepted <= '0;
            end else begin
                if (issue) issued   <= issued + 1'b1;
                if (pop)   accepted <= accepted + 1'b1;
            end
            vld_pipe[0] <= issue;
            idx_pipe[0] <= issued[ADDR_W-1:0];
            for (int i = 1; i < RAM_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
            end
        end
    end

    tri_fetch_fifo #(
        .W     (ADDR_W + TRI_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .push     (vld_pipe[RAM_LAT-1]),
        .push_dat ({idx_pipe[RAM_LAT-1], ram_data_in}),
        .pop      (pop),
        .head_dat ({tri_idx_out, tri_out}),
        .head_vld (tri_valid_out),
        .count    (fifo_count)
    );
endmodule

// File: tb/tb_tri_fetch_sched.sv
// Directed bench for tri_fetch_sched with a 2-cycle BRAM model and an in-order delivery checker.
module tb_tri_fetch_sched;
    localparam int ADDR_W = 16;
    localparam int TRI_W  = 96;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic              frame_start_in = 1'b0;
    logic [ADDR_W-1:0] num_tris_in = '0;
    logic [223:0]      pose_in = '0;
    logic [223:0]      pose_out;
    logic              busy_out, frame_done_out, ram_en_out, tri_valid_out;
    logic              tri_ready_in = 1'b0;
    logic [ADDR_W-1:0] ram_addr_out, tri_idx_out;
    logic [TRI_W-1:0]  ram_data_in, tri_out;
    logic [ADDR_W-1:0] ram_a_q;

    int errs   = 0;
    int checks = 0;

    localparam logic [223:0] P1 = {32'h3f80_0000, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666,
                                   32'h7777_8888, 32'h9999_aaaa, 32'hbbbb_cccc};
    localparam logic [223:0] P5 = {7{32'hdead_0005}};
    localparam logic [223:0] P6 = {7{32'hbeef_0006}};

    always #5 clk_in = ~clk_in;

    tri_fetch_sched dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .frame_start_in (frame_start_in),
        .num_tris_in    (num_tris_in),
        .pose_in        (pose_in),
        .pose_out       (pose_out),
        .busy_out       (busy_out),
        .frame_done_out (frame_done_out),
        .ram_addr_out   (ram_addr_out),
        .ram_en_out     (ram_en_out),
        .ram_data_in    (ram_data_in),
        .tri_out        (tri_out),
        .tri_idx_out    (tri_idx_out),
        .tri_valid_out  (tri_valid_out),
        .tri_ready_in   (tri_ready_in)
    );

    function automatic logic [95:0] tri_val(input int i);
        return {32'(i) ^ 32'ha5a5_0000, 32'(i) + 32'h100, 32'(i) * 32'd7};
    endfunction

    // Two-cycle read latency: address registered, then data registered.
    always @(posedge clk_in) begin
        ram_a_q     <= ram_addr_out;
        ram_data_in <= tri_val(int'(ram_a_q));
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_in);
        #1;
    endtask

    task automatic start_frame(input int n, input logic [223:0] p);
        frame_start_in = 1'b1;
        num_tris_in    = ADDR_W'(n);
        pose_in        = p;
        step;
        frame_start_in = 1'b0;
    endtask

    // Drain a frame: every transfer must be the next index with matching data, stalls must hold.
    task automatic collect(input string tag, input int n, input bit rand_ready);
        int        next_idx = 0;
        bit        done_seen = 0;
        bit        prev_stall = 0;
        logic [TRI_W-1:0]  prev_tri = '0;
        logic [ADDR_W-1:0] prev_idx = '0;
        for (int k = 0; k < 3000 && !done_seen; k++) begin
            tri_ready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall) begin
                check({tag, "_hold_tri"}, 256'(tri_out), 256'(prev_tri));
                check({tag, "_hold_idx"}, 256'(tri_idx_out), 256'(prev_idx));
            end
            prev_stall = tri_valid_out && !tri_ready_in;
            prev_tri   = tri_out;
            prev_idx   = tri_idx_out;
            if (tri_valid_out && tri_ready_in) begin
                check({tag, "_idx"}, 256'(tri_idx_out), 256'(next_idx));
                check({tag, "_dat"}, 256'(tri_out), 256'(tri_val(next_idx)));
                next_idx++;
            end
            step;
            if (frame_done_out) done_seen = 1;
        end
        check({tag, "_done_seen"}, 256'(done_seen), 256'(1));
        check({tag, "_count"}, 256'(next_idx), 256'(n));
        check({tag, "_busy_at_done"}, 256'(busy_out), 256'(0));
    endtask

    initial begin
        int en_cnt;

        // Reset
        rst_in = 1'b1;
        step; step;
        check("rst_pose", 256'(pose_out), 256'(0));
        check("rst_busy", 256'(busy_out), 256'(0));
        check("rst_done", 256'(frame_done_out), 256'(0));
        check("rst_en", 256'(ram_en_out), 256'(0));
        check("rst_addr", 256'(ram_addr_out), 256'(0));
        check("rst_vld", 256'(tri_valid_out), 256'(0));
        check("rst_tri", 256'(tri_out), 256'(0));
        check("rst_idx", 256'(tri_idx_out), 256'(0));
        rst_in = 1'b0;
        step;

        // 1) Four triangles, ready high: exact cycle timing
        tri_ready_in = 1'b1;
        start_frame(4, P1);
        check("t1_pose", 256'(pose_out), 256'(P1));
        for (int c = 1; c <= 9; c++) begin
            check("t1_en", 256'(ram_en_out), 256'(c >= 1 && c <= 4));
            if (c <= 4) check("t1_addr", 256'(ram_addr_out), 256'(c - 1));
            check("t1_vld", 256'(tri_valid_out), 256'(c >= 4 && c <= 7));
            if (c >= 4 && c <= 7) begin
                check("t1_idx", 256'(tri_idx_out), 256'(c - 4));
                check("t1_dat", 256'(tri_out), 256'(tri_val(c - 4)));
            end
            check("t1_done", 256'(frame_done_out), 256'(c == 8));
            check("t1_busy", 256'(busy_out), 256'(c <= 7));
            step;
        end

        // 2) Empty frame
        start_frame(0, P5);
        for (int c = 1; c <= 4; c++) begin
            check("t2_done", 256'(frame_done_out), 256'(c == 1));
            check("t2_busy", 256'(busy_out), 256'(0));
            check("t2_en", 256'(ram_en_out), 256'(0));
            step;
        end

        // 3) Ten triangles with ready low: credit limit
        tri_ready_in = 1'b0;
        start_frame(10, P1);
        en_cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            if (ram_en_out) en_cnt++;
            step;
        end
        check("t3_issues", 256'(en_cnt), 256'(4));
        check("t3_en_idle", 256'(ram_en_out), 256'(0));
        check("t3_head_vld", 256'(tri_valid_out), 256'(1));
        check("t3_head_idx", 256'(tri_idx_out), 256'(0));
        collect("t3", 10, 1'b0);

        // 4) Random backpressure
        step;
        start_frame(37, P6);
        collect("t4", 37, 1'b1);

        // 5) Start pulse while busy is ignored
        step;
        tri_ready_in = 1'b0;
        start_frame(6, P5);
        step; step;
        start_frame(20, P6);
        check("t5_pose_mid", 256'(pose_out), 256'(P5));
        collect("t5", 6, 1'b0);
        check("t5_pose_end", 256'(pose_out), 256'(P5));

        // 6) Reset with reads in flight
        step;
        tri_ready_in = 1'b0;
        start_frame(8, P1);
        step; step;
        rst_in = 1'b1;
        step;
        rst_in = 1'b0;
        check("t6_busy", 256'(busy_out), 256'(0));
        check("t6_en", 256'(ram_en_out), 256'(0));
        check("t6_addr", 256'(ram_addr_out), 256'(0));
        check("t6_vld", 256'(tri_valid_out), 256'(0));
        check("t6_tri", 256'(tri_out), 256'(0));
        check("t6_idx", 256'(tri_idx_out), 256'(0));
        check("t6_pose", 256'(pose_out), 256'(0));
        check("t6_done", 256'(frame_done_out), 256'(0));
        for (int c = 0; c < 4; c++) begin
            check("t6_no_done", 256'(frame_done_out), 256'(0));
            check("t6_no_vld", 256'(tri_valid_out), 256'(0));
            step;
        end
        start_frame(3, P6);
        collect("t6_new", 3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
